axis_icrc_append: RTL and testbench
===================================

Name: axis_icrc_append

Overview:
- Sits directly downstream of the ICRC field-masking stage in the RoCEv2 TX path.
- Computes CRC32 over the masked byte stream and appends the 4-byte ICRC to the unmasked stream.
- Emits the frame with ICRC attached toward the UDP/IP framer.
- Handles partial last beats: the ICRC goes inline when it fits; otherwise it is split across one extra beat.

Parameters:
- DATA_WIDTH, 64, stream width in bits. Legal values: 64, 128, 256, 512.
- KEEP_WIDTH, DATA_WIDTH/8, byte lanes. Derived; do not override.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- s_axis_masked_tdata  in  DATA_WIDTH  masked data; used for CRC only
- s_axis_masked_tkeep  in  KEEP_WIDTH  byte enables, contiguous from bit 0
- s_axis_masked_tvalid  in  1  input valid
- s_axis_masked_tready  out  1  input ready
- s_axis_masked_tlast  in  1  last beat of frame
- s_axis_masked_tuser  in  1  frame error flag
- s_axis_not_masked_tdata  in  DATA_WIDTH  original data, qualified by the masked-stream handshake
- m_axis_tdata  out  DATA_WIDTH  unmasked data with ICRC appended
- m_axis_tkeep  out  KEEP_WIDTH  output byte enables
- m_axis_tvalid  out  1  output valid
- m_axis_tready  in  1  output ready
- m_axis_tlast  out  1  output last
- m_axis_tuser  out  1  output error flag

Behaviour:
- Reset (rst_n low, asynchronous): m_axis_tvalid=0, tdata/tkeep/tlast/tuser=0, s_axis_masked_tready=0, FSM=IDLE, crc_reg=CRC_INIT.
  - Reset asserted mid-frame discards the frame; no partial ICRC is emitted.
- Byte order: lane i = tdata[8i+7:8i], wire order ascending. n = popcount(tkeep).
- CRC:
  - Reflected polynomial 0xEDB88320.
  - Bytes are processed lane 0 upward; only lanes with tkeep set are processed.
  - ICRC = ~crc_final, placed little-endian: first appended byte = ICRC[7:0].
- CRC_INIT is 0xFFFFFFFF, except as modified by the optional feature below.
- Output stage: single register. Input is accepted when m_axis_tready || !m_axis_tvalid, and state != EXTRA. Latency is 1 cycle.
- FSM:
  - IDLE/PAYLOAD, non-last beat accepted: output = not_masked data; crc_reg updated; state=PAYLOAD.
  - Last beat accepted, n <= KEEP_WIDTH-4:
    - ICRC goes in lanes n..n+3; tkeep gets bits n..n+3 set; tlast=1.
    - crc_reg resets to CRC_INIT; state=IDLE.
  - Last beat accepted, n > KEEP_WIDTH-4:
    - k = KEEP_WIDTH-n lanes receive ICRC bytes 0..k-1; tkeep all ones; tlast=0.
    - Remaining 4-k ICRC bytes are held; state=EXTRA.
  - EXTRA: when the output register frees, emit one beat:
    - ICRC bytes k..3 in lanes 0..3-k; tkeep = (1<<(4-k))-1; tlast=1; other lanes 0.
    - state=IDLE; crc_reg=CRC_INIT.
- Input ready is 0 while in EXTRA; no beat of the next frame is accepted until the extra beat is loaded.
- Last beat with tkeep=0: n=0, so the ICRC occupies lanes 0..3 inline.
- tuser: passed per beat. The extra beat carries the tuser of the final input beat. The ICRC is appended regardless of tuser.
- Output data lanes beyond tkeep are driven 0 on the last beat.
- Back-to-back frames: a new frame may be accepted in the cycle after an inline-ICRC last beat, with no bubble.
- tvalid must never drop while m_axis_tready is 0; data is held stable while stalled.

Optional Feature:
- Macro: ICRC_LRH_PREFIX_EN.
- Defined: CRC_INIT is the CRC state after processing 8 bytes of 0xFF from 0xFFFFFFFF (the dummy LRH for RoCEv2 over IPv4).
  - The value is computed at elaboration with the same byte-step function; no literal constant.
- Undefined: CRC_INIT=0xFFFFFFFF, giving plain CRC32 (IEEE 802.3).

Test Plan:
1. Prefix disabled, DATA_WIDTH=64. One beat "123456789": bytes 0x31..0x38 in lanes 0-7, then last beat 0x39 with tkeep=0x01.
   - Expected: output beat 2 tkeep=0x1F, lanes 1-4 = 26 39 F4 CB, tlast=1. ICRC 0xCBF43926.
2. Prefix disabled, 64-byte frame of 0x00, tkeep full on the last beat.
   - Expected: the last data beat has tlast=0, followed by an extra beat with tkeep=0x0F, tlast=1, lanes 0-3 = ~CRC32 of the 64 zero bytes (golden model). Input ready=0 for exactly one cycle.
3. 62-byte frame: last beat tkeep=0x3F (n=6).
   - Expected: lanes 6-7 = ICRC[7:0], ICRC[15:0]>>8, tkeep=0xFF, tlast=0.
   - Then an extra beat with tkeep=0x03 carrying ICRC[23:16] and ICRC[31:24].
4. Random m_axis_tready (50%) over 200 random frames of 1-300 bytes with random tuser.
   - Expected: output matches the golden model byte-for-byte, with no drop or duplication. tuser matches the final beat.
5. Assert rst_n low mid-frame during a stall, then release and send the frame from test 1.
   - Expected: m_axis_tvalid=0 immediately after reset assertion, and a correct ICRC on the new frame (no stale CRC state).
6. Prefix enabled, 40-byte frame.
   - Expected: the ICRC equals the golden CRC32 over 8 bytes of 0xFF followed by the 40 frame bytes.

Source files
------------

// File: rtl/axis_icrc_append.sv
// -----------------------------------------------------------------------------
// axis_icrc_append
//
// Purpose:
//   RoCEv2 TX ICRC insertion. This block receives two parallel streams that
//   share one handshake: a masked copy of the frame and the original
//   (unmasked) copy. CRC32 is computed over the masked bytes. The unmasked
//   bytes are forwarded, and the 4-byte ICRC is appended after them. When the
//   last beat has no room for all four ICRC bytes, the remainder is sent in one
//   extra beat.
//
// Parameters:
//   DATA_WIDTH  stream width in bits (64, 128, 256 or 512)
//   KEEP_WIDTH  byte lanes, DATA_WIDTH/8 (derived; do not override)
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   s_axis_masked_tdata/tkeep  masked data (CRC only) and contiguous byte enables
//   s_axis_masked_tvalid/ready input handshake, shared by both input streams
//   s_axis_masked_tlast/tuser  end of frame, frame error flag
//   s_axis_not_masked_tdata    original data, forwarded to the output
//   m_axis_t*                  registered output stream with the ICRC appended
//
// Build option:
//   ICRC_LRH_PREFIX_EN  if defined, the CRC is seeded as if 8 bytes of 0xFF
//                       (the dummy LRH) had already been processed.
// -----------------------------------------------------------------------------
module axis_icrc_append #(
   parameter int unsigned DATA_WIDTH = 64,
   parameter int unsigned KEEP_WIDTH = DATA_WIDTH / 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [DATA_WIDTH-1:0] s_axis_masked_tdata,
   input  logic [KEEP_WIDTH-1:0] s_axis_masked_tkeep,
   input  logic                  s_axis_masked_tvalid,
   output logic                  s_axis_masked_tready,
   input  logic                  s_axis_masked_tlast,
   input  logic                  s_axis_masked_tuser,
   input  logic [DATA_WIDTH-1:0] s_axis_not_masked_tdata,
   output logic [DATA_WIDTH-1:0] m_axis_tdata,
   output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
   output logic                  m_axis_tvalid,
   input  logic                  m_axis_tready,
   output logic                  m_axis_tlast,
   output logic                  m_axis_tuser
);

   localparam logic [31:0] POLY = 32'hEDB88320;

   function automatic logic [31:0] crc_byte(input logic [31:0] crc, input logic [7:0] data);
      logic [31:0] c;
      c = crc ^ {24'd0, data};
      for (int unsigned i = 0; i < 8; i++) begin
         c = c[0] ? ((c >> 1) ^ POLY) : (c >> 1);
      end
      return c;
   endfunction

   function automatic logic [31:0] crc_init_calc();
      logic [31:0] c;
      c = '1;
`ifdef ICRC_LRH_PREFIX_EN
      for (int unsigned i = 0; i < 8; i++) begin
         c = crc_byte(c, 8'hFF);
      end
`endif
      return c;
   endfunction

   localparam logic [31:0] CRC_INIT = crc_init_calc();

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PAYLOAD = 2'd1,
      EXTRA   = 2'd2
   } state_t;

   state_t                state, state_nx;
   logic [31:0]           crc_reg, crc_nx;
   logic                  running;
   logic [31:0]           extra_data, extra_data_nx;
   logic [3:0]            extra_keep, extra_keep_nx;
   logic                  extra_user, extra_user_nx;

   logic [DATA_WIDTH-1:0] data_nx;
   logic [KEEP_WIDTH-1:0] keep_nx;
   logic                  valid_nx, last_nx, user_nx;

   logic                  out_free, accept;
   logic [31:0]           crc_beat, icrc, n, k;
   logic [DATA_WIDTH-1:0] last_data;
   logic [KEEP_WIDTH-1:0] last_keep;

   // running holds input ready low while in reset and for the first cycle after.
   assign out_free             = m_axis_tready || !m_axis_tvalid;
   assign s_axis_masked_tready = running && out_free && (state != EXTRA);
   assign accept               = s_axis_masked_tvalid && s_axis_masked_tready;

   // CRC over the enabled lanes of the current beat, lane 0 first.
   always_comb begin
      crc_beat = crc_reg;
      for (int unsigned i = 0; i < KEEP_WIDTH; i++) begin
         if (s_axis_masked_tkeep[i]) begin
            crc_beat = crc_byte(crc_beat, s_axis_masked_tdata[8*i +: 8]);
         end
      end
   end

   assign icrc = ~crc_beat;

   always_comb begin
      n = '0;
      for (int unsigned i = 0; i < KEEP_WIDTH; i++) begin
         n = n + 32'(s_axis_masked_tkeep[i]);
      end
   end

   assign k = KEEP_WIDTH - n;

   // Last-beat layout: payload lanes 0..n-1, ICRC bytes from lane n onward
   // (truncated at the top lane), and zero in all remaining lanes. The same
   // layout serves both the inline case and the split case.
   always_comb begin
      logic [31:0] sh;
      sh        = '0;
      last_data = '0;
      last_keep = '0;
      for (int unsigned j = 0; j < KEEP_WIDTH; j++) begin
         if (j < n) begin
            last_data[8*j +: 8] = s_axis_not_masked_tdata[8*j +: 8];
            last_keep[j]        = 1'b1;
         end else if (j < n + 32'd4) begin
            sh                  = icrc >> (8 * (j - n));
            last_data[8*j +: 8] = sh[7:0];
            last_keep[j]        = 1'b1;
         end
      end
   end

   always_comb begin
      state_nx      = state;
      crc_nx        = crc_reg;
      extra_data_nx = extra_data;
      extra_keep_nx = extra_keep;
      extra_user_nx = extra_user;
      data_nx       = m_axis_tdata;
      keep_nx       = m_axis_tkeep;
      last_nx       = m_axis_tlast;
      user_nx       = m_axis_tuser;
      valid_nx      = m_axis_tvalid && !m_axis_tready;

      case (state)
         IDLE, PAYLOAD: begin
            if (accept) begin
               valid_nx = 1'b1;
               user_nx  = s_axis_masked_tuser;
               if (!s_axis_masked_tlast) begin
                  data_nx  = s_axis_not_masked_tdata;
                  keep_nx  = s_axis_masked_tkeep;
                  last_nx  = 1'b0;
                  crc_nx   = crc_beat;
                  state_nx = PAYLOAD;
               end else begin
                  data_nx = last_data;
                  keep_nx = last_keep;
                  crc_nx  = CRC_INIT;
                  if (n <= KEEP_WIDTH - 4) begin
                     last_nx  = 1'b1;
                     state_nx = IDLE;
                  end else begin
                     // k lanes were filled; keep the other 4-k ICRC bytes, shifted down.
                     last_nx       = 1'b0;
                     extra_data_nx = icrc >> (8 * k);
                     extra_keep_nx = 4'hF >> k;
                     extra_user_nx = s_axis_masked_tuser;
                     state_nx      = EXTRA;
                  end
               end
            end
         end
         EXTRA: begin
            if (out_free) begin
               valid_nx = 1'b1;
               data_nx  = DATA_WIDTH'(extra_data);
               keep_nx  = KEEP_WIDTH'(extra_keep);
               last_nx  = 1'b1;
               user_nx  = extra_user;
               crc_nx   = CRC_INIT;
               state_nx = IDLE;
            end
         end
         default: begin
            state_nx = IDLE;
            crc_nx   = CRC_INIT;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         crc_reg       <= CRC_INIT;
         running       <= 1'b0;
         extra_data    <= '0;
         extra_keep    <= '0;
         extra_user    <= 1'b0;
         m_axis_tdata  <= '0;
         m_axis_tkeep  <= '0;
         m_axis_tvalid <= 1'b0;
         m_axis_tlast  <= 1'b0;
         m_axis_tuser  <= 1'b0;
      end else begin
         state         <= state_nx;
         crc_reg       <= crc_nx;
         running       <= 1'b1;
         extra_data    <= extra_data_nx;
         extra_keep    <= extra_keep_nx;
         extra_user    <= extra_user_nx;
         m_axis_tdata  <= data_nx;
         m_axis_tkeep  <= keep_nx;
         m_axis_tvalid <= valid_nx;
         m_axis_tlast  <= last_nx;
         m_axis_tuser  <= user_nx;
      end
   end

endmodule

// File: tb/tb_axis_icrc_append.sv
// -----------------------------------------------------------------------------
// tb_axis_icrc_append
//
// Purpose:
//   Self-checking bench for axis_icrc_append at DATA_WIDTH=64. The expected
//   output beats come from a bitwise reference CRC32 and are queued when a
//   frame is driven. They are popped and compared when the DUT emits beats.
//   A table of directed frames also checks the output beat count and the
//   appended ICRC. Multi-cycle corner cases are handled by hand-written
//   sequences. ICRC_LRH_PREFIX_EN selects the reference seed.
// -----------------------------------------------------------------------------
module tb_axis_icrc_append;

   localparam int DW = 64;
   localparam int KW = DW / 8;
`ifdef ICRC_LRH_PREFIX_EN
   localparam bit PREFIX = 1'b1;
`else
   localparam bit PREFIX = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [DW-1:0] s_axis_masked_tdata;
   logic [KW-1:0] s_axis_masked_tkeep;
   logic          s_axis_masked_tvalid;
   logic          s_axis_masked_tready;
   logic          s_axis_masked_tlast;
   logic          s_axis_masked_tuser;
   logic [DW-1:0] s_axis_not_masked_tdata;
   logic [DW-1:0] m_axis_tdata;
   logic [KW-1:0] m_axis_tkeep;
   logic          m_axis_tvalid;
   logic          m_axis_tready = 1'b1;
   logic          m_axis_tlast;
   logic          m_axis_tuser;

   always #5 clk = ~clk;

   axis_icrc_append #(.DATA_WIDTH(DW)) dut (
      .clk                     (clk),
      .rst_n                   (rst_n),
      .s_axis_masked_tdata     (s_axis_masked_tdata),
      .s_axis_masked_tkeep     (s_axis_masked_tkeep),
      .s_axis_masked_tvalid    (s_axis_masked_tvalid),
      .s_axis_masked_tready    (s_axis_masked_tready),
      .s_axis_masked_tlast     (s_axis_masked_tlast),
      .s_axis_masked_tuser     (s_axis_masked_tuser),
      .s_axis_not_masked_tdata (s_axis_not_masked_tdata),
      .m_axis_tdata            (m_axis_tdata),
      .m_axis_tkeep            (m_axis_tkeep),
      .m_axis_tvalid           (m_axis_tvalid),
      .m_axis_tready           (m_axis_tready),
      .m_axis_tlast            (m_axis_tlast),
      .m_axis_tuser            (m_axis_tuser)
   );

   typedef struct {
      logic [DW-1:0] data;
      logic [KW-1:0] keep;
      logic          last;
      logic          user;
   } beat_t;

   typedef struct {
      int          len;
      int          pat;
      bit          user;
      bit          has_exp;
      logic [31:0] exp_icrc;
      int          exp_beats;
   } vec_t;

   beat_t       sb[$];
   logic [7:0]  cap[$];
   int          cap_beats;
   logic [7:0]  nm[$];
   logic [7:0]  mk[$];
   logic [31:0] exp_icrc_g;
   int          n_checks = 0;
   int          n_fail = 0;
   bit          rand_ready = 1'b0;
   bit          ready_force = 1'b1;
   vec_t        vecs[8];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] ref_crc_step(input logic [31:0] c, input logic [7:0] b);
      logic [31:0] r;
      r = c;
      for (int i = 0; i < 8; i++) begin
         if (r[0] ^ b[i]) r = (r >> 1) ^ 32'hEDB88320;
         else             r = r >> 1;
      end
      return r;
   endfunction

   function automatic logic [31:0] ref_crc_init();
      logic [31:0] c;
      c = 32'hFFFF_FFFF;
      if (PREFIX) begin
         for (int i = 0; i < 8; i++) c = ref_crc_step(c, 8'hFF);
      end
      return c;
   endfunction

   // Pattern 0: ASCII digits; 1: zeros; 2: random with some bytes masked to FF; 3: ramp.
   task automatic build(input int len, input int pat);
      nm.delete();
      mk.delete();
      for (int i = 0; i < len; i++) begin
         logic [7:0] b;
         case (pat)
            0:       b = 8'h31 + 8'(i);
            1:       b = 8'h00;
            2:       b = 8'($urandom);
            default: b = 8'(i);
         endcase
         nm.push_back(b);
         mk.push_back((pat == 2 && $urandom_range(0, 5) == 0) ? 8'hFF : b);
      end
   endtask

   task automatic expect_frame(input bit user);
      logic [31:0] c;
      logic [7:0]  ob[$];
      int          nin, nout;
      beat_t       b;
      c = ref_crc_init();
      foreach (mk[i]) c = ref_crc_step(c, mk[i]);
      exp_icrc_g = ~c;
      ob = nm;
      for (int i = 0; i < 4; i++) ob.push_back(exp_icrc_g[8*i +: 8]);
      nin  = (nm.size() == 0) ? 1 : (nm.size() + KW - 1) / KW;
      nout = (ob.size() + KW - 1) / KW;
      for (int bi = 0; bi < nout; bi++) begin
         b.data = '0;
         b.keep = '0;
         b.last = (bi == nout - 1);
         b.user = (bi >= nin - 1) ? user : 1'b0;
         for (int j = 0; j < KW; j++) begin
            if (bi * KW + j < ob.size()) begin
               b.data[8*j +: 8] = ob[bi * KW + j];
               b.keep[j]        = 1'b1;
            end
         end
         sb.push_back(b);
      end
   endtask

   // Must be entered 1 time unit after a rising edge; returns at the same phase.
   task automatic send_frame(input bit user);
      int nin, to;
      nin = (nm.size() == 0) ? 1 : (nm.size() + KW - 1) / KW;
      for (int bi = 0; bi < nin; bi++) begin
         s_axis_masked_tdata     = '0;
         s_axis_not_masked_tdata = '0;
         s_axis_masked_tkeep     = '0;
         for (int j = 0; j < KW; j++) begin
            if (bi * KW + j < nm.size()) begin
               s_axis_not_masked_tdata[8*j +: 8] = nm[bi * KW + j];
               s_axis_masked_tdata[8*j +: 8]     = mk[bi * KW + j];
               s_axis_masked_tkeep[j]            = 1'b1;
            end
         end
         s_axis_masked_tlast  = (bi == nin - 1);
         s_axis_masked_tuser  = s_axis_masked_tlast ? user : 1'b0;
         s_axis_masked_tvalid = 1'b1;
         to = 0;
         forever begin
            @(negedge clk);
            if (s_axis_masked_tready) break;
            to++;
            if (to > 2000) begin
               chk("send_timeout", 64'd1, 64'd0);
               s_axis_masked_tvalid = 1'b0;
               return;
            end
         end
         @(posedge clk);
         #1;
      end
      s_axis_masked_tvalid = 1'b0;
      s_axis_masked_tlast  = 1'b0;
   endtask

   task automatic drain();
      int to;
      to = 0;
      while (sb.size() != 0 && to < 3000) begin
         @(posedge clk);
         to++;
      end
      chk("drain_pending_beats", 64'(sb.size()), 64'd0);
      @(posedge clk);
      #1;
   endtask

   task automatic run_row(input vec_t v);
      logic [31:0] got;
      int          sz;
      build(v.len, v.pat);
      cap.delete();
      cap_beats = 0;
      expect_frame(v.user);
      send_frame(v.user);
      drain();
      chk("row_beats", 64'(cap_beats), 64'(v.exp_beats));
      sz  = cap.size();
      got = (sz >= 4) ? {cap[sz-1], cap[sz-2], cap[sz-3], cap[sz-4]} : 32'hxxxx_xxxx;
      chk("row_icrc", 64'(got), 64'(v.has_exp ? v.exp_icrc : exp_icrc_g));
   endtask

   always @(posedge clk) begin
      #1;
      m_axis_tready = rand_ready ? 1'($urandom_range(0, 1)) : ready_force;
   end

   beat_t prev;
   bit    prev_stall = 1'b0;

   always @(negedge clk) begin
      beat_t e;
      if (!rst_n) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            chk("stall_valid_held", 64'(m_axis_tvalid), 64'd1);
            chk("stall_data_held", m_axis_tdata, prev.data);
         end
         if (m_axis_tvalid && m_axis_tready) begin
            chk("beat_expected", 64'(sb.size() > 0), 64'd1);
            if (sb.size() > 0) begin
               e = sb.pop_front();
               chk("out_tdata", m_axis_tdata, e.data);
               chk("out_tkeep", 64'(m_axis_tkeep), 64'(e.keep));
               chk("out_tlast", 64'(m_axis_tlast), 64'(e.last));
               chk("out_tuser", 64'(m_axis_tuser), 64'(e.user));
            end
            for (int j = 0; j < KW; j++) begin
               if (m_axis_tkeep[j]) cap.push_back(m_axis_tdata[8*j +: 8]);
            end
            cap_beats++;
         end
         prev_stall = m_axis_tvalid && !m_axis_tready;
         prev.data  = m_axis_tdata;
      end
   end

   initial begin
      #800000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{9,  0, 1'b0, !PREFIX, 32'hCBF4_3926, 2};
      vecs[1] = '{62, 2, 1'b1, 1'b0,    32'h0,         9};
      vecs[2] = '{0,  1, 1'b0, !PREFIX, 32'h0000_0000, 1};
      vecs[3] = '{4,  3, 1'b0, 1'b0,    32'h0,         1};
      vecs[4] = '{5,  3, 1'b1, 1'b0,    32'h0,         2};
      vecs[5] = '{8,  3, 1'b0, 1'b0,    32'h0,         2};
      vecs[6] = '{40, 3, 1'b1, 1'b0,    32'h0,         6};
      vecs[7] = '{13, 2, 1'b0, 1'b0,    32'h0,         3};

      s_axis_masked_tdata     = '0;
      s_axis_not_masked_tdata = '0;
      s_axis_masked_tkeep     = '0;
      s_axis_masked_tvalid    = 1'b0;
      s_axis_masked_tlast     = 1'b0;
      s_axis_masked_tuser     = 1'b0;

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
      chk("rst_tdata", m_axis_tdata, 64'd0);
      chk("rst_tkeep", 64'(m_axis_tkeep), 64'd0);
      chk("rst_tlast", 64'(m_axis_tlast), 64'd0);
      chk("rst_tuser", 64'(m_axis_tuser), 64'd0);
      chk("rst_s_tready", 64'(s_axis_masked_tready), 64'd0);
      rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;

      // Directed frames
      for (int i = 0; i < 8; i++) run_row(vecs[i]);

      // 64 zero bytes: ICRC entirely in an extra beat, input ready low for one cycle
      build(64, 1);
      expect_frame(1'b0);
      send_frame(1'b0);
      @(negedge clk);
      chk("extra_ready_low", 64'(s_axis_masked_tready), 64'd0);
      @(negedge clk);
      chk("extra_ready_back", 64'(s_axis_masked_tready), 64'd1);
      @(posedge clk);
      #1;
      drain();

      // Inline ICRC: next frame can be accepted in the following cycle
      build(9, 0);
      expect_frame(1'b1);
      send_frame(1'b1);
      @(negedge clk);
      chk("b2b_ready", 64'(s_axis_masked_tready), 64'd1);
      @(posedge clk);
      #1;
      drain();

      // Random backpressure and frame lengths
      rand_ready = 1'b1;
      for (int f = 0; f < 200; f++) begin
         bit u;
         u = 1'($urandom_range(0, 1));
         build($urandom_range(1, 300), 2);
         expect_frame(u);
         send_frame(u);
         if ($urandom_range(0, 3) == 0) begin
            repeat ($urandom_range(1, 3)) begin
               @(posedge clk);
               #1;
            end
         end
      end
      drain();
      rand_ready  = 1'b0;
      ready_force = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      // Reset while a frame is stalled in the output register
      ready_force = 1'b0;
      @(posedge clk);
      #1;
      s_axis_masked_tdata     = 64'h0807_0605_0403_0201;
      s_axis_not_masked_tdata = 64'h0807_0605_0403_0201;
      s_axis_masked_tkeep     = '1;
      s_axis_masked_tlast     = 1'b0;
      s_axis_masked_tvalid    = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("stalled_before_reset", 64'(m_axis_tvalid), 64'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("reset_clears_tvalid", 64'(m_axis_tvalid), 64'd0);
      chk("reset_clears_s_tready", 64'(s_axis_masked_tready), 64'd0);
      s_axis_masked_tvalid = 1'b0;
      repeat (2) @(negedge clk);
      rst_n       = 1'b1;
      ready_force = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      run_row(vecs[0]);

      chk("scoreboard_empty", 64'(sb.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
